// File: rtl/forth_dmem_io.sv
// forth_dmem_io: data-bus responder for the forth core.
// It provides word RAM, a buffered output stream, an input holding register
// and a free-running tick counter. Every data access gets a registered
// read result one cycle later.
module forth_dmem_io #(
    parameter int RAM_WORDS = 240,
    parameter int OUT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  daddr,
    input  logic [15:0] ddata_write,
    input  logic        dwrite,
    output logic [15:0] ddata_read,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(OUT_DEPTH);

    localparam logic [7:0] ADDR_OUT    = 8'hF0;
    localparam logic [7:0] ADDR_STATUS = 8'hF1;
    localparam logic [7:0] ADDR_IN     = 8'hF2;
    localparam logic [7:0] ADDR_TICKS  = 8'hF3;

    // Word RAM, contents survive reset.
    logic [15:0] ram_r [0:RAM_WORDS-1];

    // Output FIFO storage and bookkeeping.
    logic [15:0] fifo_mem_r [0:OUT_DEPTH-1];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   count_r;
    logic          overflow_r;

    // Input holding register.
    logic [15:0] in_hold_r;
    logic        in_full_r;

    // Tick counter.
    logic [15:0] ticks_r;

    logic [15:0] ddata_read_r;
    logic [15:0] rd_next_s;

    logic sel_ram_s;
    logic ram_we_s;
    logic wr_out_s;
    logic wr_status_s;
    logic wr_in_s;
    logic wr_ticks_s;
    logic out_empty_s;
    logic out_full_s;
    logic pop_s;
    logic push_s;
    logic drop_s;
    logic clr_ovf_s;
    logic capture_s;

    assign sel_ram_s   = ({24'd0, daddr} < RAM_WORDS);
    assign ram_we_s    = dwrite && sel_ram_s;
    assign wr_out_s    = dwrite && (daddr == ADDR_OUT);
    assign wr_status_s = dwrite && (daddr == ADDR_STATUS);
    assign wr_in_s     = dwrite && (daddr == ADDR_IN);
    assign wr_ticks_s  = dwrite && (daddr == ADDR_TICKS);

    assign out_empty_s = (count_r == {(AW + 1){1'b0}});
    assign out_full_s  = (count_r == FULL_CNT);
    assign pop_s       = !out_empty_s && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_s      = wr_out_s && (!out_full_s || pop_s);
    assign drop_s      = wr_out_s && out_full_s && !pop_s;
    assign clr_ovf_s   = wr_status_s && ddata_write[2];
    assign capture_s   = in_valid && !in_full_r;

    assign out_valid  = !out_empty_s;
    assign out_data   = fifo_mem_r[rd_ptr_r];
    assign in_ready   = !in_full_r;
    assign ddata_read = ddata_read_r;

    // RAM write port (no reset so contents are retained).
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[daddr] <= ddata_write;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= ddata_write;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag: set by a dropped push, cleared by software.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf_s) begin
            overflow_r <= 1'b0;
        end
    end

    // Input holding register: capture on handshake, release on any IN write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_full_r <= 1'b0;
            in_hold_r <= 16'h0000;
        end else if (capture_s) begin
            in_full_r <= 1'b1;
            in_hold_r <= in_data;
        end else if (wr_in_s) begin
            in_full_r <= 1'b0;
        end
    end

    // Free-running tick counter; a software load wins over the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ticks_r <= 16'h0000;
        end else if (wr_ticks_s) begin
            ticks_r <= ddata_write;
        end else begin
            ticks_r <= ticks_r + 16'd1;
        end
    end

    // Read-data mux over the pre-edge state of the addressed location.
    always_comb begin
        rd_next_s = 16'h0000;
        if (sel_ram_s) begin
            rd_next_s = ram_r[daddr];
        end else begin
            case (daddr)
                ADDR_STATUS: rd_next_s = {12'h000, in_full_r, overflow_r, out_full_s, out_empty_s};
                ADDR_IN:     rd_next_s = in_hold_r;
                ADDR_TICKS:  rd_next_s = ticks_r;
                default:     rd_next_s = 16'h0000;
            endcase
        end
    end

    // Registered read data, one cycle of latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ddata_read_r <= 16'h0000;
        end else begin
            ddata_read_r <= rd_next_s;
        end
    end

endmodule

// File: tb/tb_forth_dmem_io.sv
// Testbench for forth_dmem_io: directed scenarios plus random traffic,
// checked through scoreboards fed by a behavioural model.
module tb_forth_dmem_io;

    localparam int RW = 240;
    localparam int D  = 4;

    logic        clk;
    logic        reset;
    logic [7:0]  daddr;
    logic [15:0] ddata_write;
    logic        dwrite;
    logic [15:0] ddata_read;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;

    forth_dmem_io #(.RAM_WORDS(RW), .OUT_DEPTH(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .daddr       (daddr),
        .ddata_write (ddata_write),
        .dwrite      (dwrite),
        .ddata_read  (ddata_read),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk_rd;
        logic [15:0] rd;
        bit          ov;
        bit          ir;
    } exp_t;

    exp_t        rq[$];
    logic [15:0] exp_out[$];

    // Behavioural model state
    logic [15:0] m_ram [256];
    bit          m_ramv [256];
    logic [15:0] m_fifo[$];
    bit          m_ovf;
    bit          m_full;
    logic [15:0] m_in;
    bit          m_inv;
    logic [15:0] m_ticks;

    int n_checks;
    int n_fail;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    // One bus cycle: drive inputs, predict the edge, queue the expectation.
    task automatic cyc(input logic [7:0] a, input bit we, input logic [15:0] wd,
                       input bit iv, input logic [15:0] id, input bit ordy);
        exp_t e;
        bit   pop;
        bit   full;
        bit   cap;
        daddr       = a;
        dwrite      = we;
        ddata_write = wd;
        in_valid    = iv;
        in_data     = id;
        out_ready   = ordy;
        e.chk_rd = 1'b1;
        e.rd     = 16'h0000;
        if (a < RW) begin
            e.chk_rd = m_ramv[a];
            e.rd     = m_ram[a];
        end else if (a == 8'hF1) begin
            e.rd = {12'h000, m_full, m_ovf, m_fifo.size() == D, m_fifo.size() == 0};
        end else if (a == 8'hF2) begin
            e.chk_rd = m_inv;
            e.rd     = m_in;
        end else if (a == 8'hF3) begin
            e.rd = m_ticks;
        end
        pop  = ordy && (m_fifo.size() > 0);
        full = (m_fifo.size() == D);
        cap  = iv && !m_full;
        if (pop) void'(m_fifo.pop_front());
        if (we && a == 8'hF0) begin
            if (!full || pop) begin
                m_fifo.push_back(wd);
                exp_out.push_back(wd);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (we && a == 8'hF1 && wd[2]) m_ovf = 1'b0;
        if (we && a == 8'hF2) m_full = 1'b0;
        if (we && a == 8'hF3) m_ticks = wd;
        else m_ticks = m_ticks + 16'd1;
        if (we && a < RW) begin
            m_ram[a]  = wd;
            m_ramv[a] = 1'b1;
        end
        if (cap) begin
            m_full = 1'b1;
            m_in   = id;
            m_inv  = 1'b1;
        end
        e.ov = (m_fifo.size() > 0);
        e.ir = !m_full;
        rq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        cyc(a, 1'b1, d, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        cyc(a, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(8'h10, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_out.delete();
        m_ovf   = 1'b0;
        m_full  = 1'b0;
        m_inv   = 1'b0;
        m_in    = 16'h0000;
        m_ticks = 16'h0000;
    endtask

    // Monitor: registered read data and flags after each edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rq.size() > 0) begin
            e = rq.pop_front();
            if (e.chk_rd) check("ddata_read", {16'h0, ddata_read}, {16'h0, e.rd});
            check("out_valid", {31'h0, out_valid}, {31'h0, e.ov});
            check("in_ready", {31'h0, in_ready}, {31'h0, e.ir});
        end
    end

    // Monitor: output stream handshakes, compared in order against pushes.
    always begin
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_out.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_extra: got word %h expected none at %0t", out_data, $time);
            end else begin
                check("out_data", {16'h0, out_data}, {16'h0, exp_out.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a;
        int         r;
        n_checks    = 0;
        n_fail      = 0;
        for (int i = 0; i < 256; i++) m_ramv[i] = 1'b0;
        model_reset();
        reset       = 1'b1;
        daddr       = 8'h00;
        dwrite      = 1'b0;
        ddata_write = 16'h0000;
        in_valid    = 1'b0;
        in_data     = 16'h0000;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_ddata_read", {16'h0, ddata_read}, 32'h0);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_in_ready", {31'h0, in_ready}, 32'h1);
        reset = 1'b0;

        // RAM write/read and unmapped reads
        wr(8'h05, 16'h1234);
        rd(8'h05);
        wr(8'hEF, 16'h5AA5);
        rd(8'hEF);
        rd(8'hF5);
        rd(8'hF0);

        // Overflow and drain
        wr(8'hF0, 16'h0011);
        wr(8'hF0, 16'h0022);
        wr(8'hF0, 16'h0033);
        wr(8'hF0, 16'h0044);
        wr(8'hF0, 16'h0055);
        rd(8'hF1);
        drain(5);
        wr(8'hF1, 16'h0004);
        rd(8'hF1);

        // Push into a full FIFO while the head leaves
        wr(8'hF0, 16'h0021);
        wr(8'hF0, 16'h0022);
        wr(8'hF0, 16'h0023);
        wr(8'hF0, 16'h0024);
        cyc(8'hF0, 1'b1, 16'h0066, 1'b0, 16'h0000, 1'b1);
        rd(8'hF1);
        drain(5);

        // Input holding register
        cyc(8'h10, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
        rd(8'hF2);
        rd(8'hF2);
        rd(8'hF1);
        wr(8'hF2, 16'h0000);
        cyc(8'h10, 1'b0, 16'h0000, 1'b1, 16'hCAFE, 1'b0);
        rd(8'hF2);

        // Tick counter wrap
        wr(8'hF3, 16'hFFFE);
        rd(8'h10);
        rd(8'hF3);
        rd(8'hF3);
        rd(8'hF3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: a = 8'($urandom_range(0, 15));
                4:          a = 8'hF0;
                5:          a = 8'hF1;
                6:          a = 8'hF2;
                7:          a = 8'hF3;
                8:          a = 8'($urandom_range(244, 255));
                default:    a = 8'hEF;
            endcase
            cyc(a, ($urandom_range(0, 1) == 1), 16'($urandom()),
                ($urandom_range(0, 1) == 1), 16'($urandom()),
                ($urandom_range(0, 9) < 7));
        end

        // Reset mid-stream with queued words and a full input register
        wr(8'h07, 16'hABCD);
        wr(8'hF2, 16'h0000);
        wr(8'hF0, 16'h0101);
        wr(8'hF0, 16'h0202);
        cyc(8'hF3, 1'b0, 16'h0000, 1'b1, 16'h5A5A, 1'b0);
        dwrite   = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("midreset_out_valid", {31'h0, out_valid}, 32'h0);
        check("midreset_in_ready", {31'h0, in_ready}, 32'h1);
        check("midreset_ddata_read", {16'h0, ddata_read}, 32'h0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        rd(8'h07);
        rd(8'hF1);
        rd(8'hF3);
        rd(8'h10);

        if (rq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rq_drain: got %0d pending expected 0", rq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
